// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions, FSM states and ALU
// encodings shared by the multi-cycle core and its ALU.
package cpu_pkg;

  localparam int IW      = 19;
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 14;
  localparam int RS1_MSB = 13;
  localparam int RS1_LSB = 11;
  localparam int RS2_MSB = 10;
  localparam int RS2_LSB = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int IMM_MSB = 4;
  localparam int OFF_MSB = 7;
  localparam int TGT_MSB = 13;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_ADDI = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_JMP  = 5'b01001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational DW-wide ALU (add/sub/and/or/xor/signed slt)
// with a zero-result flag.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 19
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    alu_op,
  output logic [DW-1:0] result,
  output logic          zero
);

  logic lt;

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(DW-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle FETCH/DECODE/EXEC/WB core for the 19-bit ISA.
// Define CPU_PERF_COUNTERS_EN to add cycle_cnt/instret_cnt outputs.
module cpu_core_mc
  import cpu_pkg::*;
#(
  parameter int             DW       = 19,
  parameter int             PCW      = 19,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [IW-1:0]  imem_rdata,
  output logic           retire,
  output logic           halted,
  output logic           illegal,
  output logic           zero_flag,
`ifdef CPU_PERF_COUNTERS_EN
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    instret_cnt,
`endif
  output logic [PCW-1:0] dbg_pc
);

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]   res_q, res_d;
  logic            br_q, br_d;
  logic            req_q, req_d;
  logic            retire_q, retire_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            zero_q, zero_d;
  logic [DW-1:0]   rf_q [8];
  logic [DW-1:0]   rf_d [8];

  logic [4:0]      op;
  logic [2:0]      rs1, rs2, rd;
  logic [DW-1:0]   imm_x, rd1, rd2;
  logic [PCW-1:0]  off_x, tgt_x, pc_seq, pc_nxt;
  logic [2:0]      alu_op;
  logic [DW-1:0]   alu_b, alu_res;
  logic            alu_zero, is_alu, legal;

  assign op    = ir_q[OP_MSB:OP_LSB];
  assign rs1   = ir_q[RS1_MSB:RS1_LSB];
  assign rs2   = ir_q[RS2_MSB:RS2_LSB];
  assign rd    = ir_q[RD_MSB:RD_LSB];
  assign imm_x = DW'($signed(ir_q[IMM_MSB:0]));
  assign off_x = PCW'($signed(ir_q[OFF_MSB:0]));
  assign tgt_x = PCW'(ir_q[TGT_MSB:0]);

  // R0 is hardwired to zero on the read side
  assign rd1 = (rs1 == 3'd0) ? '0 : rf_q[rs1];
  assign rd2 = (rs2 == 3'd0) ? '0 : rf_q[rs2];

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    is_alu = 1'b1;
    legal  = 1'b1;
    unique case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_ADDI: alu_b  = imm_x;
      OP_SLT:  alu_op = ALU_SLT;
      OP_NOP, OP_BEQ, OP_JMP, OP_HALT:
        is_alu = 1'b0;
      default: begin
        is_alu = 1'b0;
        legal  = 1'b0;
      end
    endcase
  end

  cpu_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_comb begin
    pc_seq = pc_q + PCW'(1);
    pc_nxt = pc_seq;
    if (op == OP_JMP)
      pc_nxt = tgt_x;
    else if (op == OP_BEQ && br_q)
      pc_nxt = pc_seq + off_x;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    br_d      = br_q;
    illegal_d = illegal_q;
    zero_d    = zero_q;
    retire_d  = 1'b0;
    rf_d      = rf_q;
    unique case (state_q)
      S_FETCH: begin
        // valid only counts once the request is actually out
        if (req_q && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rd1;
        b_d     = rd2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d    = alu_res;
        br_d     = (a_q == b_q);
        retire_d = 1'b1;
        state_d  = S_WB;
        if (is_alu) zero_d = alu_zero;
        if (!legal) illegal_d = 1'b1;
      end
      S_WB: begin
        if (is_alu && rd != 3'd0) rf_d[rd] = res_q;
        pc_d    = pc_nxt;
        state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    req_d    = (state_d == S_FETCH);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      req_q     <= 1'b0;
      retire_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      zero_q    <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      br_q      <= br_d;
      req_q     <= req_d;
      retire_q  <= retire_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      zero_q    <= zero_d;
      rf_q      <= rf_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign dbg_pc    = pc_q;
  assign retire    = retire_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign zero_flag = zero_q;

`ifdef CPU_PERF_COUNTERS_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q + 32'(state_q != S_HALT);
    ins_d = ins_q + 32'(retire_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`endif

endmodule

// File: doc/cpu_core_mc.md
Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle 19-bit CPU top.
- Runs a fixed 19-bit instruction set on a configurable datapath width.
- Fetches instructions through a request/valid memory handshake, so it tolerates wait-stated instruction memory.
- Adds immediate ALU ops, BEQ/JMP control flow, HALT, a hardwired-zero R0, a sticky illegal-opcode flag and a retire pulse.

Parameters:
- DW, 19: datapath and register width in bits; legal range ≥ 8.
- PCW, 19: program counter and instruction address width.
- RESET_PC, 0: PC value loaded on reset (PCW bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PCW  fetch address; always equals the PC.
- imem_valid  in  1  instruction data valid; sampled only while imem_req=1.
- imem_rdata  in  19  instruction word.
- retire  out  1  one-cycle pulse per completed instruction, HALT included.
- halted  out  1  core is in HALT state.
- illegal  out  1  sticky: an undefined opcode was executed.
- zero_flag  out  1  zero result of the most recent ALU operation.
- dbg_pc  out  PCW  current PC.

Behaviour:
- Reset is asynchronous, active-high, one clock domain. While reset is high:
  - PC=RESET_PC; R1..R7=0; state=FETCH.
  - imem_req=0, retire=0, halted=0, illegal=0, zero_flag=0.
  - imem_req rises in the first cycle after reset deasserts.
- Instruction fields: opcode[18:14], rs1[13:11], rs2[10:8], rd[7:5], imm5[4:0], off8[7:0], tgt14[13:0].
- Register file:
  - 8 x DW registers with 2 combinational read ports and 1 synchronous write port.
  - Reads of R0 return 0; writes to R0 are discarded.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
  - FETCH: imem_req=1 and imem_addr=PC. On the first edge with imem_valid=1, latch imem_rdata into IR and go to DECODE. imem_valid=1 in the same cycle as the request is legal, giving a one-cycle FETCH. Otherwise stay in FETCH.
  - DECODE: latch A=R[rs1] and B=R[rs2]; form the sign-extended imm5/off8 to DW/PCW bits.
  - EXEC: ALU result into RES; zero_flag updated for ALU and ADDI ops only; branch condition computed.
  - WB: register write if required; PC update; retire=1; go to FETCH. HALT goes to HALT instead.
  - HALT: imem_req=0, halted=1. Leave only through reset.
- Latency: 4 cycles per instruction plus instruction-memory wait cycles.
- Opcodes:
  - 00000 NOP.
  - 00001 ADD, 00010 SUB, 00011 AND, 00100 OR, 00101 XOR: rd = rs1 op rs2.
  - 00110 ADDI: rd = rs1 + sext(imm5).
  - 00111 SLT: rd = (signed rs1 < signed rs2) ? 1 : 0.
  - 01000 BEQ: if A==B, PC = PC+1+sext(off8).
  - 01001 JMP: PC = zext(tgt14).
  - 11111 HALT.
  - Any other opcode: executes as NOP and sets illegal.
- PC update: default PC+1. All PC arithmetic wraps modulo 2^PCW; all data arithmetic wraps modulo 2^DW.
- No forwarding hazards exist: each instruction completes WB before the next fetch.
- Boundary rules:
  - imem_valid while imem_req=0 is ignored.
  - Reset mid-fetch drops imem_req immediately; a late imem_valid is ignored.
  - A branch from PC=2^PCW-1 with off8=0 wraps to PC=0.
  - If PCW<14, tgt14 is truncated to PCW bits.

Optional Feature:
- Macro: CPU_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle outside HALT.
  - instret_cnt increments on each retire.
  - Both wrap at 2^32.
- Undefined: neither port nor its logic exists.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams;
  - FSM state enum;
  - instruction field bit positions;
  - ALU operation encoding.
- One sub-module: cpu_alu, combinational, DW-parametrised. Inputs a, b, alu_op; outputs result, zero.
- The register file lives inline in the core.

Test Plan:
- Reset, then ADDI R1,R0,5; ADDI R2,R0,-3; ADD R3,R1,R2 with zero-wait memory -> R3=2. Each instruction retires exactly 4 cycles apart; zero_flag=0.
- SUB R4,R1,R1 -> R4=0, zero_flag=1. ADDI R0,R1,7 -> R0 still reads 0.
- With R1=R2=5, BEQ at PC=10 with off8=-4 -> next imem_addr=7. BEQ with R1!=R2 -> next imem_addr=11. JMP tgt14=0x100 -> imem_addr=0x100.
- imem_valid delayed 3 cycles -> imem_req and imem_addr stable for the whole wait; retire spacing is 7 cycles. A spurious imem_valid during DECODE has no effect.
- Opcode 10101 -> illegal=1 and stays 1; PC advances by 1; no register changes. Then HALT -> halted=1, imem_req=0, and retire pulses exactly once.
- Assert reset while in FETCH with a wait-state pending -> imem_req=0 immediately and all outputs at reset values. Fetch restarts at RESET_PC one cycle after reset deasserts.
